// File: rtl/shift_pkg.sv
// Shared constants, FSM state encoding and direction codes for the barrel-shifter sequencer.
package shift_pkg;
   localparam int DATA_W   = 32;
   localparam int AMT_W    = 5;
   localparam int N_STAGES = 5;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A settle time of zero would sample Z before B has propagated.
   function automatic int settle_eff(input int cycles);
      return (cycles < 1) ? 1 : cycles;
   endfunction
endpackage

// File: rtl/shift_stage_dec.sv
// One barrel-shifter stage decode: amount bit plus direction to one-hot LEFT/NO_SHIFT/RIGHT with complements.
module shift_stage_dec
   import shift_pkg::*;
(
   input  logic en,
   input  logic dir,
   output logic left,
   output logic no_shift,
   output logic right,
   output logic left_not,
   output logic no_shift_not,
   output logic right_not
);
   assign left         = en & (dir == DIR_LEFT);
   assign right        = en & (dir == DIR_RIGHT);
   assign no_shift     = ~en;
   assign left_not     = ~left;
   assign no_shift_not = ~no_shift;
   assign right_not    = ~right;
endmodule

// File: rtl/shift_ctrl_seq.sv
// Request/settle/capture sequencer driving a 5-stage 32-bit barrel shifter with registered one-hot stage controls.
module shift_ctrl_seq
   import shift_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_DIR,
   input  logic [AMT_W-1:0]  REQ_AMT,
   input  logic [DATA_W-1:0] REQ_DATA,
   output logic [DATA_W-1:0] B,
   output logic LEFT_1, LEFT_2, LEFT_4, LEFT_8, LEFT_16,
   output logic LEFT_1_NOT, LEFT_2_NOT, LEFT_4_NOT, LEFT_8_NOT, LEFT_16_NOT,
   output logic NO_SHIFT_1, NO_SHIFT_2, NO_SHIFT_4, NO_SHIFT_8, NO_SHIFT_16,
   output logic NO_SHIFT_1_NOT, NO_SHIFT_2_NOT, NO_SHIFT_4_NOT, NO_SHIFT_8_NOT, NO_SHIFT_16_NOT,
   output logic RIGHT_1, RIGHT_2, RIGHT_4, RIGHT_8, RIGHT_16,
   output logic RIGHT_1_NOT, RIGHT_2_NOT, RIGHT_4_NOT, RIGHT_8_NOT, RIGHT_16_NOT,
   input  logic [DATA_W-1:0] Z_IN,
   output logic              RES_VALID,
   input  logic              RES_READY,
   output logic [DATA_W-1:0] RES_DATA
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(settle_eff(SETTLE_CYCLES) - 1);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [DATA_W-1:0]   b_reg, res_data_reg;
   logic [N_STAGES-1:0] left_reg, no_shift_reg, right_reg;
   logic [N_STAGES-1:0] left_not_reg, no_shift_not_reg, right_not_reg;
   logic [N_STAGES-1:0] dec_left, dec_no_shift, dec_right;
   logic [N_STAGES-1:0] dec_left_not, dec_no_shift_not, dec_right_not;
   logic [AMT_W-1:0]    dec_en;
   logic                ld_req, ld_rel, cap;

   assign ld_req = (state_reg == IDLE) && REQ_VALID;
   assign ld_rel = (state_reg == DONE) && RES_READY;
   assign cap    = (state_reg == DRIVE) && (cnt_reg == '0);

   // Forcing the amount to zero on release makes the decoders emit pass-through.
   assign dec_en = ld_req ? REQ_AMT : '0;

   generate
      for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_dec
         shift_stage_dec u_dec (
            .en           (dec_en[gi]),
            .dir          (REQ_DIR),
            .left         (dec_left[gi]),
            .no_shift     (dec_no_shift[gi]),
            .right        (dec_right[gi]),
            .left_not     (dec_left_not[gi]),
            .no_shift_not (dec_no_shift_not[gi]),
            .right_not    (dec_right_not[gi])
         );
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (REQ_VALID)       state_next = DRIVE;
         DRIVE:   if (cnt_reg == '0)   state_next = DONE;
         DONE:    if (RES_READY)       state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   always_comb begin
      REQ_READY = (state_reg == IDLE);
      RES_VALID = (state_reg == DONE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_reg          <= '0;
         b_reg            <= '0;
         res_data_reg     <= '0;
         left_reg         <= '0;
         no_shift_reg     <= '1;
         right_reg        <= '0;
         left_not_reg     <= '1;
         no_shift_not_reg <= '0;
         right_not_reg    <= '1;
      end else begin
         if (ld_req) begin
            b_reg   <= REQ_DATA;
            cnt_reg <= CNT_LOAD;
         end else if ((state_reg == DRIVE) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
         end
         if (cap) res_data_reg <= Z_IN;
         if (ld_req || ld_rel) begin
            left_reg         <= dec_left;
            no_shift_reg     <= dec_no_shift;
            right_reg        <= dec_right;
            left_not_reg     <= dec_left_not;
            no_shift_not_reg <= dec_no_shift_not;
            right_not_reg    <= dec_right_not;
         end
      end
   end

   assign B        = b_reg;
   assign RES_DATA = res_data_reg;

   assign {LEFT_16, LEFT_8, LEFT_4, LEFT_2, LEFT_1} = left_reg;
   assign {LEFT_16_NOT, LEFT_8_NOT, LEFT_4_NOT, LEFT_2_NOT, LEFT_1_NOT} = left_not_reg;
   assign {NO_SHIFT_16, NO_SHIFT_8, NO_SHIFT_4, NO_SHIFT_2, NO_SHIFT_1} = no_shift_reg;
   assign {NO_SHIFT_16_NOT, NO_SHIFT_8_NOT, NO_SHIFT_4_NOT, NO_SHIFT_2_NOT, NO_SHIFT_1_NOT} = no_shift_not_reg;
   assign {RIGHT_16, RIGHT_8, RIGHT_4, RIGHT_2, RIGHT_1} = right_reg;
   assign {RIGHT_16_NOT, RIGHT_8_NOT, RIGHT_4_NOT, RIGHT_2_NOT, RIGHT_1_NOT} = right_not_reg;
endmodule

// File: tb/tb_shift_ctrl_seq.sv
// Scoreboard bench for shift_ctrl_seq driving a behavioural 5-stage barrel shifter.
module tb_shift_ctrl_seq;
   localparam int S = 2;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        REQ_VALID, REQ_READY, REQ_DIR;
   logic [4:0]  REQ_AMT;
   logic [31:0] REQ_DATA, B, Z_IN, RES_DATA;
   logic        RES_VALID, RES_READY;
   logic LEFT_1, LEFT_2, LEFT_4, LEFT_8, LEFT_16;
   logic LEFT_1_NOT, LEFT_2_NOT, LEFT_4_NOT, LEFT_8_NOT, LEFT_16_NOT;
   logic NO_SHIFT_1, NO_SHIFT_2, NO_SHIFT_4, NO_SHIFT_8, NO_SHIFT_16;
   logic NO_SHIFT_1_NOT, NO_SHIFT_2_NOT, NO_SHIFT_4_NOT, NO_SHIFT_8_NOT, NO_SHIFT_16_NOT;
   logic RIGHT_1, RIGHT_2, RIGHT_4, RIGHT_8, RIGHT_16;
   logic RIGHT_1_NOT, RIGHT_2_NOT, RIGHT_4_NOT, RIGHT_8_NOT, RIGHT_16_NOT;

   int checks = 0, failures = 0, cyc = 0;
   int n_acc = 0, n_res = 0, n_discard = 0, rand_acc = 0;
   logic rv_q = 1'b0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   shift_ctrl_seq #(.SETTLE_CYCLES(S), .CNT_W(3)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DIR(REQ_DIR),
      .REQ_AMT(REQ_AMT), .REQ_DATA(REQ_DATA), .B(B),
      .LEFT_1(LEFT_1), .LEFT_2(LEFT_2), .LEFT_4(LEFT_4), .LEFT_8(LEFT_8), .LEFT_16(LEFT_16),
      .LEFT_1_NOT(LEFT_1_NOT), .LEFT_2_NOT(LEFT_2_NOT), .LEFT_4_NOT(LEFT_4_NOT),
      .LEFT_8_NOT(LEFT_8_NOT), .LEFT_16_NOT(LEFT_16_NOT),
      .NO_SHIFT_1(NO_SHIFT_1), .NO_SHIFT_2(NO_SHIFT_2), .NO_SHIFT_4(NO_SHIFT_4),
      .NO_SHIFT_8(NO_SHIFT_8), .NO_SHIFT_16(NO_SHIFT_16),
      .NO_SHIFT_1_NOT(NO_SHIFT_1_NOT), .NO_SHIFT_2_NOT(NO_SHIFT_2_NOT), .NO_SHIFT_4_NOT(NO_SHIFT_4_NOT),
      .NO_SHIFT_8_NOT(NO_SHIFT_8_NOT), .NO_SHIFT_16_NOT(NO_SHIFT_16_NOT),
      .RIGHT_1(RIGHT_1), .RIGHT_2(RIGHT_2), .RIGHT_4(RIGHT_4), .RIGHT_8(RIGHT_8), .RIGHT_16(RIGHT_16),
      .RIGHT_1_NOT(RIGHT_1_NOT), .RIGHT_2_NOT(RIGHT_2_NOT), .RIGHT_4_NOT(RIGHT_4_NOT),
      .RIGHT_8_NOT(RIGHT_8_NOT), .RIGHT_16_NOT(RIGHT_16_NOT),
      .Z_IN(Z_IN), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA)
   );

   logic [4:0] l, ln, ns, nsn, r, rn;
   assign l   = {LEFT_16, LEFT_8, LEFT_4, LEFT_2, LEFT_1};
   assign ln  = {LEFT_16_NOT, LEFT_8_NOT, LEFT_4_NOT, LEFT_2_NOT, LEFT_1_NOT};
   assign ns  = {NO_SHIFT_16, NO_SHIFT_8, NO_SHIFT_4, NO_SHIFT_2, NO_SHIFT_1};
   assign nsn = {NO_SHIFT_16_NOT, NO_SHIFT_8_NOT, NO_SHIFT_4_NOT, NO_SHIFT_2_NOT, NO_SHIFT_1_NOT};
   assign r   = {RIGHT_16, RIGHT_8, RIGHT_4, RIGHT_2, RIGHT_1};
   assign rn  = {RIGHT_16_NOT, RIGHT_8_NOT, RIGHT_4_NOT, RIGHT_2_NOT, RIGHT_1_NOT};

   // Combinational barrel shifter: stage 2^k steered by its select lines.
   always_comb begin
      Z_IN = B;
      for (int k = 0; k < 5; k++) begin
         if (l[k])      Z_IN = Z_IN << (1 << k);
         else if (r[k]) Z_IN = Z_IN >> (1 << k);
      end
   end

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // One-hot and complement invariant on every stage, every cycle.
   always @(negedge CLK) begin
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ((32'(l[k]) + 32'(ns[k]) + 32'(r[k])) != 1 ||
             ln[k] !== ~l[k] || nsn[k] !== ~ns[k] || rn[k] !== ~r[k]) begin
            failures++;
            $display("FAIL invariant stage%0d: l/ns/r=%b%b%b nots=%b%b%b required one-hot with exact complements",
                     1 << k, l[k], ns[k], r[k], ln[k], nsn[k], rn[k]);
         end
      end
   end

   // Request side: expected response computed from shift arithmetic at accept time.
   always @(negedge CLK) begin : push_blk
      exp_t e;
      if (RST_N && REQ_VALID && REQ_READY) begin
         e.data = REQ_DIR ? (REQ_DATA << REQ_AMT) : (REQ_DATA >> REQ_AMT);
         e.cyc  = cyc;
         sb_q.push_back(e);
         n_acc++;
      end
   end

   // Result side: latency on rising RES_VALID, data on each result handshake.
   always @(negedge CLK) begin : mon_blk
      exp_t e;
      if (!RST_N) begin
         rv_q = 1'b0;
      end else begin
         if (RES_VALID && !rv_q) begin
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_result: got %h required no result", RES_DATA);
            end else begin
               check("latency", 32'(cyc - sb_q[0].cyc), 32'(1 + S));
            end
         end
         if (RES_VALID && RES_READY && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("res_data", RES_DATA, e.data);
            n_res++;
            $display("txn %0d result %h expected %h", n_res, RES_DATA, e.data);
         end
         rv_q = RES_VALID;
      end
   end

   task automatic wait_res(input int budget);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!RES_VALID && n < budget);
      checks++;
      if (!RES_VALID) begin
         failures++;
         $display("FAIL res_valid_timeout: got RES_VALID=0 after %0d cycles required 1", budget);
      end
   endtask

   // Present a request and return at posedge+1 of the accepting edge.
   task automatic send(input logic dir, input logic [4:0] amt, input logic [31:0] data);
      int n = 0;
      logic acc = 1'b0;
      REQ_DIR = dir; REQ_AMT = amt; REQ_DATA = data; REQ_VALID = 1'b1;
      while (!acc && n < 50) begin
         @(negedge CLK);
         acc = REQ_READY;
         @(posedge CLK);
         #1;
         n++;
      end
      REQ_VALID = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL req_accept_timeout: got REQ_READY=0 for %0d cycles required 1", n);
      end
   endtask

   initial begin
      RST_N = 1'b0; REQ_VALID = 1'b0; REQ_DIR = 1'b0; REQ_AMT = '0; REQ_DATA = '0; RES_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_req_ready", 32'(REQ_READY), 32'd1);
      check("rst_res_valid", 32'(RES_VALID), 32'd0);
      check("rst_res_data", RES_DATA, 32'h0);
      check("rst_b", B, 32'h0);
      check("rst_no_shift", 32'(ns), 32'h1f);
      @(negedge CLK) RST_N = 1'b1;

      // Left by 1
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      send(1'b1, 5'd1, 32'h0000_0001);
      check("l1_left", 32'(l), 32'h01);
      check("l1_no_shift", 32'(ns), 32'h1e);
      check("l1_right", 32'(r), 32'h00);
      check("l1_b", B, 32'h1);
      check("l1_req_ready", 32'(REQ_READY), 32'd0);
      wait_res(20);
      check("l1_res_data", RES_DATA, 32'h2);
      @(posedge CLK); #1;
      check("l1_release_ready", 32'(REQ_READY), 32'd1);
      check("l1_release_ns", 32'(ns), 32'h1f);

      // Right by 31 with backpressure and an ignored request pulse during DRIVE
      RES_READY = 1'b0;
      send(1'b0, 5'd31, 32'h8000_0000);
      check("r31_right", 32'(r), 32'h1f);
      REQ_DATA = 32'h1234_5678; REQ_AMT = 5'd3; REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      check("busy_req_ready", 32'(REQ_READY), 32'd0);
      wait_res(20);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("bp_res_valid", 32'(RES_VALID), 32'd1);
         check("bp_res_data", RES_DATA, 32'h1);
         check("bp_b", B, 32'h8000_0000);
         check("bp_right", 32'(r), 32'h1f);
         check("bp_req_ready", 32'(REQ_READY), 32'd0);
      end
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      check("bp_idle_ready", 32'(REQ_READY), 32'd1);
      check("bp_idle_valid", 32'(RES_VALID), 32'd0);
      check("bp_idle_ns", 32'(ns), 32'h1f);

      // Zero amount still fully sequenced
      RES_READY = 1'b1;
      send(1'b0, 5'd0, 32'hDEAD_BEEF);
      wait_res(20);
      check("amt0_res_data", RES_DATA, 32'hDEAD_BEEF);
      @(posedge CLK); #1;

      // Asynchronous reset in the middle of DRIVE
      RES_READY = 1'b0;
      send(1'b1, 5'd4, 32'h0000_000F);
      check("mid_left4", 32'(l), 32'h04);
      #3;
      RST_N = 1'b0;
      #1;
      check("arst_ns", 32'(ns), 32'h1f);
      check("arst_left", 32'(l), 32'h00);
      check("arst_right", 32'(r), 32'h00);
      check("arst_req_ready", 32'(REQ_READY), 32'd1);
      check("arst_res_valid", 32'(RES_VALID), 32'd0);
      check("arst_b", B, 32'h0);
      n_discard += sb_q.size();
      sb_q.delete();
      repeat (3) begin
         @(negedge CLK);
         check("arst_hold_valid", 32'(RES_VALID), 32'd0);
      end
      RST_N = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      send(1'b1, 5'd4, 32'h0000_000F);
      wait_res(20);
      check("post_rst_res_data", RES_DATA, 32'h0000_00F0);
      @(posedge CLK); #1;

      // Random back-to-back with REQ_VALID held and random result backpressure
      for (int n = 0; n < 1000; n++) begin
         int   k = 0;
         logic acc = 1'b0;
         REQ_DIR = 1'($urandom); REQ_AMT = 5'($urandom); REQ_DATA = $urandom; REQ_VALID = 1'b1;
         while (!acc && k < 100) begin
            @(negedge CLK);
            acc = REQ_READY;
            @(posedge CLK);
            #1;
            RES_READY = 1'($urandom_range(0, 1));
            k++;
         end
         if (acc) rand_acc++;
         else begin
            checks++; failures++;
            $display("FAIL rand_accept_timeout: got no accept in %0d cycles required accept", k);
         end
      end
      REQ_VALID = 1'b0;
      RES_READY = 1'b1;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge CLK);
      repeat (2) @(negedge CLK);
      check("rand_accepted", 32'(rand_acc), 32'd1000);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("no_loss_dup", 32'(n_res), 32'(n_acc - n_discard));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
